ifu_prefetch: RTL and testbench

Instruction prefetch unit sitting directly upstream of the if_id register, which feeds the decode stage. Issues sequential word fetches on the instruction bus and buffers returned words in a small in-order FIFO. Presents one instruction plus its address per cycle to if_id. On a jump from ex, it redirects the fetch PC, empties the FIFO and silently drops responses still in flight.

---
 rtl/ifu_prefetch.sv | 127 ++++++++++++
 tb/tb_ifu_prefetch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - sequential instruction prefetch with in-order FIFO and jump flush
// Optional feature: define PREFETCH_BYPASS_EN to forward a response straight to inst_o when the FIFO is empty.
module ifu_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   fifo_addr [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fly_addr  [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, fly_rd, fly_wr;
  logic [CW-1:0] count, pending, discard;

  logic [CW:0] credit_used;
  logic        fire, rsp, drop, keep, fifo_ne, bypass, pop, fifo_pop, push;
  logic        unused_jump_lsb;

  assign unused_jump_lsb = ^jump_addr_i[1:0];

  // In-flight words hold credit until they return, so stale responses can never overflow the FIFO.
  assign credit_used = {1'b0, count} + {1'b0, pending};
  assign ibus_req_o  = !rst && !jump_flag_i && (credit_used < DEPTH_W);
  assign ibus_addr_o = pc;
  assign fire        = ibus_req_o && ibus_gnt_i;

  assign rsp     = ibus_rvalid_i && (pending != '0);
  assign drop    = jump_flag_i || (discard != '0);
  assign keep    = rsp && !drop;
  assign fifo_ne = (count != '0);

`ifdef PREFETCH_BYPASS_EN
  assign bypass = keep && !fifo_ne;
`else
  assign bypass = 1'b0;
`endif

  assign inst_valid_o = !jump_flag_i && (fifo_ne || bypass);
  assign pop          = inst_valid_o && !hold_flag_i;
  assign fifo_pop     = pop && fifo_ne;
  assign push         = keep && !(bypass && !hold_flag_i);

  always_comb begin
    inst_o      = INST_NOP;
    inst_addr_o = 32'h0;
    if (inst_valid_o) begin
      if (fifo_ne) begin
        inst_o      = fifo_inst[rd_ptr];
        inst_addr_o = fifo_addr[rd_ptr];
      end else begin
        inst_o      = ibus_rdata_i;
        inst_addr_o = fly_addr[fly_rd];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      fly_rd  <= '0;
      fly_wr  <= '0;
      count   <= '0;
      pending <= '0;
      discard <= '0;
    end else begin
      pending <= pending + CW'(fire) - CW'(rsp);
      if (fire) begin
        fly_wr <= fly_wr + 1'b1;
        pc     <= pc + 32'd4;
      end
      if (rsp) begin
        fly_rd <= fly_rd + 1'b1;
      end
      if (jump_flag_i) begin
        // No request is issued in a jump cycle, so this never collides with the pc increment.
        pc      <= {jump_addr_i[31:2], 2'b00};
        count   <= '0;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        discard <= pending - CW'(rsp);
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (fifo_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(push) - CW'(fifo_pop);
        if (rsp && (discard != '0)) begin
          discard <= discard - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      fly_addr[fly_wr] <= pc;
    end
    if (push && !jump_flag_i) begin
      fifo_addr[wr_ptr] <= fly_addr[fly_rd];
      fifo_inst[wr_ptr] <= ibus_rdata_i;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - directed self-checking bench for ifu_prefetch with an in-order bus model
module tb_ifu_prefetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i = 1'b0;
  logic        ibus_rvalid_i = 1'b0;
  logic [31:0] ibus_rdata_i = 32'h0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        hold_flag_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  ifu_prefetch dut (
    .clk          (clk),
    .rst          (rst),
    .ibus_req_o   (ibus_req_o),
    .ibus_addr_o  (ibus_addr_o),
    .ibus_gnt_i   (ibus_gnt_i),
    .ibus_rvalid_i(ibus_rvalid_i),
    .ibus_rdata_i (ibus_rdata_i),
    .jump_flag_i  (jump_flag_i),
    .jump_addr_i  (jump_addr_i),
    .hold_flag_i  (hold_flag_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        rq[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          gnt_mode = 0;
  bit          stray = 1'b0;
  logic        o_req, o_valid;
  logic [31:0] o_raddr, o_addr, o_inst;
  int          checks = 0;
  int          failures = 0;

  // One bus cycle: present the due response, decide grant, record the new request, sample outputs.
  task automatic tick();
    rsp_t r;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = 32'h0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = rq[0].data;
      void'(rq.pop_front());
    end else if (stray) begin
      ibus_rvalid_i = 1'b1;
      ibus_rdata_i  = 32'hDEAD_BEEF;
    end
    case (gnt_mode)
      0:       ibus_gnt_i = 1'b1;
      1:       ibus_gnt_i = ((cyc % 2) == 0);
      default: ibus_gnt_i = ($urandom_range(1, 0) == 1);
    endcase
    #1;
    if (ibus_req_o && ibus_gnt_i) begin
      r.data = ibus_addr_o;
      r.due  = cyc + int'($urandom_range(lat_max, lat_min));
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      rq.push_back(r);
    end
    o_req   = ibus_req_o;
    o_raddr = ibus_addr_o;
    o_valid = inst_valid_o;
    o_addr  = inst_addr_o;
    o_inst  = inst_o;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jump_flag_i = 1'b0;
    hold_flag_i = 1'b0;
    stray = 1'b0;
    gnt_mode = 0;
    lat_min = 1;
    lat_max = 1;
    rq.delete();
    tick();
    tick();
    rst = 1'b0;
    rq.delete();
    cyc = 0;
    last_due = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", o_req); end
    checks++; if (o_raddr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", o_raddr); end
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
    checks++; if (o_inst !== NOP) begin failures++; $display("FAIL reset_inst got=%h exp=%h", o_inst, NOP); end
    checks++; if (o_addr !== 32'h0) begin failures++; $display("FAIL reset_iaddr got=%h exp=0", o_addr); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 0) begin
        checks++; if (o_req !== 1'b1 || o_raddr !== 32'h0) begin failures++; $display("FAIL stream_first_req req=%b addr=%h exp 1/0", o_req, o_raddr); end
      end
      if (k < 2) begin
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_early k=%0d got=%b exp=0", k, o_valid); end
      end else begin
        checks++; if (o_valid !== 1'b1 || o_addr !== 32'(4*(k-2)) || o_inst !== 32'(4*(k-2))) begin
          failures++; $display("FAIL stream_out k=%0d v=%b addr=%h inst=%h exp addr=%h", k, o_valid, o_addr, o_inst, 32'(4*(k-2)));
        end
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    hold_flag_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k >= 4) begin
        checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL hold_req k=%0d got=%b exp=0", k, o_req); end
      end
      if (k == 9) begin
        checks++; if (o_valid !== 1'b1 || o_addr !== 32'h0) begin failures++; $display("FAIL hold_head v=%b addr=%h exp 1/0", o_valid, o_addr); end
      end
    end
    hold_flag_i = 1'b0;
    for (int k = 10; k < 15; k++) begin
      tick();
      if (k == 10) begin
        checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL hold_release_req got=%b exp=0", o_req); end
      end
      checks++; if (o_valid !== 1'b1 || o_addr !== 32'(4*(k-10)) || o_inst !== 32'(4*(k-10))) begin
        failures++; $display("FAIL hold_drain k=%0d v=%b addr=%h exp=%h", k, o_valid, o_addr, 32'(4*(k-10)));
      end
    end
  endtask

  task automatic test_jump();
    do_reset();
    lat_min = 3;
    lat_max = 3;
    for (int k = 0; k < 9; k++) begin
      jump_flag_i = (k == 2);
      jump_addr_i = 32'h103;
      tick();
      if (k == 2) begin
        checks++; if (o_req !== 1'b0 || o_valid !== 1'b0) begin failures++; $display("FAIL jump_cycle req=%b v=%b exp 0/0", o_req, o_valid); end
      end
      if (k == 3) begin
        checks++; if (o_req !== 1'b1 || o_raddr !== 32'h100) begin failures++; $display("FAIL jump_target req=%b addr=%h exp 1/100", o_req, o_raddr); end
      end
      if (k >= 3 && k <= 6) begin
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL jump_stale k=%0d v=%b addr=%h exp v=0", k, o_valid, o_addr); end
      end
      if (k >= 7) begin
        checks++; if (o_valid !== 1'b1 || o_addr !== 32'(32'h100 + 4*(k-7)) || o_inst !== 32'(32'h100 + 4*(k-7))) begin
          failures++; $display("FAIL jump_out k=%0d v=%b addr=%h inst=%h exp=%h", k, o_valid, o_addr, o_inst, 32'(32'h100 + 4*(k-7)));
        end
      end
    end
    jump_flag_i = 1'b0;
  endtask

  task automatic test_jump_hold();
    do_reset();
    hold_flag_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      jump_flag_i = (k == 2);
      jump_addr_i = 32'h200;
      if (k == 3) hold_flag_i = 1'b0;
      tick();
      if (k == 2) begin
        checks++; if (o_req !== 1'b0 || o_valid !== 1'b0) begin failures++; $display("FAIL jh_cycle req=%b v=%b exp 0/0", o_req, o_valid); end
      end
      if (k == 3) begin
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL jh_empty v=%b exp=0", o_valid); end
        checks++; if (o_req !== 1'b1 || o_raddr !== 32'h200) begin failures++; $display("FAIL jh_target req=%b addr=%h exp 1/200", o_req, o_raddr); end
      end
      if (k == 4) begin
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL jh_gap v=%b exp=0", o_valid); end
      end
      if (k == 5) begin
        checks++; if (o_valid !== 1'b1 || o_addr !== 32'h200) begin failures++; $display("FAIL jh_out v=%b addr=%h exp 1/200", o_valid, o_addr); end
      end
    end
    jump_flag_i = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_addr;
    int nout;
    do_reset();
    gnt_mode = 2;
    lat_min = 1;
    lat_max = 3;
    exp_addr = 32'h0;
    nout = 0;
    for (int k = 0; k < 300; k++) begin
      hold_flag_i = ($urandom_range(3, 0) == 0);
      tick();
      checks++; if (int'(dut.count) + int'(dut.pending) > 4) begin
        failures++; $display("FAIL rand_credit k=%0d used=%0d exp<=4", k, int'(dut.count) + int'(dut.pending));
      end
      if (o_valid && !hold_flag_i) begin
        checks++; if (o_addr !== exp_addr || o_inst !== exp_addr) begin
          failures++; $display("FAIL rand_order k=%0d addr=%h inst=%h exp=%h", k, o_addr, o_inst, exp_addr);
        end
        exp_addr = exp_addr + 32'd4;
        nout++;
      end
    end
    hold_flag_i = 1'b0;
    checks++; if (nout < 60) begin failures++; $display("FAIL rand_progress got=%0d exp>=60", nout); end
  endtask

  task automatic test_reset_full();
    do_reset();
    hold_flag_i = 1'b1;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    checks++; if (o_req !== 1'b0) begin failures++; $display("FAIL rf_req_in_rst got=%b exp=0", o_req); end
    rst = 1'b0;
    hold_flag_i = 1'b0;
    rq.delete();
    cyc = 0;
    last_due = 0;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_inst !== NOP || o_addr !== 32'h0) begin
      failures++; $display("FAIL rf_outputs v=%b inst=%h addr=%h exp 0/%h/0", o_valid, o_inst, o_addr, NOP);
    end
    checks++; if (o_req !== 1'b1 || o_raddr !== 32'h0) begin failures++; $display("FAIL rf_req req=%b addr=%h exp 1/0", o_req, o_raddr); end
    tick();
    checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL rf_stray v=%b inst=%h exp v=0", o_valid, o_inst); end
    tick();
    checks++; if (o_valid !== 1'b1 || o_addr !== 32'h0 || o_inst !== 32'h0) begin
      failures++; $display("FAIL rf_first v=%b addr=%h inst=%h exp 1/0/0", o_valid, o_addr, o_inst);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_hold();
    test_jump();
    test_jump_hold();
    test_random();
    test_reset_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1);
  end

endmodule
